pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Merges four hold/flush sources into one consistent set of stage-register controls:
  - data-memory wait
  - multi-cycle divider
  - load-use hazard
  - taken-branch flush
- Sits beside the stage registers and drives their write-enable and bubble/flush inputs.
- Also keeps a stall-cycle performance counter and a sticky memory-timeout error flag.

Parameters:
MEM_TIMEOUT, 255, MEM_WAIT cycles before err_o is set (1..65535).
CNT_W, 16, width of stall_cnt_o.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  reset; synchronous, active-high.
id_ex_memread_i  in  1  instruction in EX is a load.
id_ex_rt_i  in  5  destination register of the load in EX.
if_id_rs_i  in  5  rs of the instruction in ID.
if_id_rt_i  in  5  rt of the instruction in ID.
branch_taken_i  in  1  branch resolved taken in ID this cycle.
dmem_req_i  in  1  MEM-stage instruction is accessing data memory.
dmem_ack_i  in  1  data memory completes the access this cycle.
div_start_i  in  1  EX-stage instruction is a DIV/DIVU (held while it sits in EX).
div_done_i  in  1  divider result valid this cycle.
pc_write_o  out  1  1 = PC updates.
if_id_write_o  out  1  1 = IF/ID register loads.
if_id_flush_o  out  1  1 = IF/ID loads a NOP.
id_ex_write_o  out  1  1 = ID/EX register loads.
id_ex_bubble_o  out  1  1 = ID/EX loads a NOP (control bits zeroed).
ex_mem_write_o  out  1  1 = EX/MEM register loads.
ex_mem_bubble_o  out  1  1 = EX/MEM loads a NOP.
mem_wb_bubble_o  out  1  1 = MEM/WB loads a NOP.
state_o  out  2  current FSM state (RUN=0, MEM_WAIT=1, DIV_WAIT=2).
err_o  out  1  sticky memory-timeout flag.
stall_cnt_o  out  CNT_W  saturating count of cycles with pc_write_o=0.

Behaviour:
- Reset (rst_i=1 at a clock edge, including mid-stall):
  - state = RUN; err_o = 0; stall_cnt_o = 0; timeout counter = 0.
  - All outputs are combinational from state and inputs. In RUN with idle inputs: every *_write_o = 1 and every flush/bubble output = 0.
- Condition terms:
  - mem_hold = dmem_req_i & ~dmem_ack_i.
  - load_use = id_ex_memread_i & (id_ex_rt_i != 0) & (id_ex_rt_i == if_id_rs_i | id_ex_rt_i == if_id_rt_i).
- Priority, evaluated each cycle (highest first):
  1. MEM freeze: state == MEM_WAIT & ~dmem_ack_i, or state == RUN & mem_hold.
     - pc, if_id, id_ex and ex_mem writes = 0; mem_wb_bubble_o = 1.
     - All other flush/bubble outputs = 0.
  2. DIV freeze: state == DIV_WAIT & ~div_done_i, or state == RUN & div_start_i & ~div_done_i.
     - pc, if_id and id_ex writes = 0; ex_mem_write_o = 1; ex_mem_bubble_o = 1.
  3. Load-use (RUN only): pc_write_o = 0; if_id_write_o = 0; id_ex_bubble_o = 1.
     - Gives exactly one bubble, because the load advances next cycle.
  4. Branch flush (RUN only): if_id_flush_o = 1; PC still writes the branch target.
     - branch_taken_i is ignored whenever 1–3 are active: the branch stays in ID and is re-resolved later.
- FSM transitions:
  - RUN -> MEM_WAIT on mem_hold.
  - MEM_WAIT -> RUN on dmem_ack_i; that ack cycle releases all stages (normal RUN outputs).
  - RUN -> DIV_WAIT on div_start_i & ~div_done_i & ~mem_hold.
  - DIV_WAIT -> RUN on div_done_i; the done cycle releases all stages.
  - A request with ack/done in the same cycle causes no stall and no state change.
  - DIV_WAIT never exits to MEM_WAIT: MEM is empty while EX is held.
- Timeout:
  - Counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
  - When it reaches MEM_TIMEOUT, err_o <= 1. err_o stays 1 until reset; the FSM keeps waiting.
  - The counter saturates.
- stall_cnt_o:
  - +1 on every cycle with pc_write_o = 0.
  - Saturates at all-ones and never wraps.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum (RUN, MEM_WAIT, DIV_WAIT)
  - stage-control struct bundling the eight write/flush/bubble bits
  - constant REG_ZERO = 5'd0
- One sub-module, load_use_detect: combinational load_use term from the four hazard inputs.
- Timeout counter, stall counter and FSM stay in the top.

Test Plan:
- Load-use: memread=1, id_ex_rt=5, if_id_rs=5 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; state stays 0; stall_cnt 0->1.
- Load to $0: memread=1, rt=0, rs=0 -> no stall, all writes 1.
- Memory wait: dmem_req=1, ack low 3 cycles then high -> state 1 for 3 cycles, mem_wb_bubble=1 and all writes 0 for 3 cycles, release on ack cycle, stall_cnt=3.
- Divider with coincident hazard: div_start=1, div_done after 4 cycles, load_use and branch_taken also asserted -> ex_mem_bubble=1 for 4 cycles, no id_ex_bubble, no if_id_flush; state returns to 0.
- Timeout and reset: MEM_TIMEOUT=4, req with no ack -> err_o=1 after 4 MEM_WAIT cycles and stays set; rst_i=1 in MEM_WAIT -> next cycle state=0, err_o=0, stall_cnt=0.
- Branch: branch_taken=1 with no hazard -> if_id_flush=1, pc_write=1 for exactly 1 cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// FSM states, stage-register control bundle and hazard constants.
package pipe_ctrl_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int         TMO_W    = 16;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DIV_WAIT = 2'd2
   } state_t;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_write;
      logic id_ex_bubble;
      logic ex_mem_write;
      logic ex_mem_bubble;
      logic mem_wb_bubble;
   } stage_ctrl_t;

   localparam stage_ctrl_t CTRL_RUN = '{
      pc_write:      1'b1,
      if_id_write:   1'b1,
      if_id_flush:   1'b0,
      id_ex_write:   1'b1,
      id_ex_bubble:  1'b0,
      ex_mem_write:  1'b1,
      ex_mem_bubble: 1'b0,
      mem_wb_bubble: 1'b0
   };

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: load in EX feeding an operand of ID.
// Loads targeting $0 never create a dependency.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       i_memread,
   input  logic [4:0] i_ex_rt,
   input  logic [4:0] i_id_rs,
   input  logic [4:0] i_id_rt,
   output logic       o_load_use
);

   logic w_match;

   assign w_match    = (i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt);
   assign o_load_use = i_memread & (i_ex_rt != REG_ZERO) & w_match;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Merges memory wait, divider, load-use and branch flush controls.
module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_ex_memread_i,
   input  logic [4:0]       id_ex_rt_i,
   input  logic [4:0]       if_id_rs_i,
   input  logic [4:0]       if_id_rt_i,
   input  logic             branch_taken_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ack_i,
   input  logic             div_start_i,
   input  logic             div_done_i,
   output logic             pc_write_o,
   output logic             if_id_write_o,
   output logic             if_id_flush_o,
   output logic             id_ex_write_o,
   output logic             id_ex_bubble_o,
   output logic             ex_mem_write_o,
   output logic             ex_mem_bubble_o,
   output logic             mem_wb_bubble_o,
   output logic [1:0]       state_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);

   state_t            r_state;
   state_t            w_state_nxt;
   stage_ctrl_t       w_ctrl;
   logic              w_mem_hold;
   logic              w_load_use;
   logic              w_mem_frz;
   logic              w_div_frz;
   logic [TMO_W-1:0]  r_tmo;
   logic [TMO_W-1:0]  w_tmo_inc;
   logic              r_err;
   logic [CNT_W-1:0]  r_stall_cnt;

   load_use_detect u_lud (
      .i_memread  (id_ex_memread_i),
      .i_ex_rt    (id_ex_rt_i),
      .i_id_rs    (if_id_rs_i),
      .i_id_rt    (if_id_rt_i),
      .o_load_use (w_load_use)
   );

   assign w_mem_hold = dmem_req_i & ~dmem_ack_i;

   assign w_mem_frz = (r_state == MEM_WAIT & ~dmem_ack_i)
                    | (r_state == RUN & w_mem_hold);

   assign w_div_frz = (r_state == DIV_WAIT & ~div_done_i)
                    | (r_state == RUN & div_start_i & ~div_done_i);

   // Branch is deliberately ignored under any stall: it stays in ID.
   always_comb begin
      w_ctrl = CTRL_RUN;
      if (w_mem_frz) begin
         w_ctrl.pc_write      = 1'b0;
         w_ctrl.if_id_write   = 1'b0;
         w_ctrl.id_ex_write   = 1'b0;
         w_ctrl.ex_mem_write  = 1'b0;
         w_ctrl.mem_wb_bubble = 1'b1;
      end else if (w_div_frz) begin
         w_ctrl.pc_write      = 1'b0;
         w_ctrl.if_id_write   = 1'b0;
         w_ctrl.id_ex_write   = 1'b0;
         w_ctrl.ex_mem_bubble = 1'b1;
      end else if (r_state == RUN && w_load_use) begin
         w_ctrl.pc_write      = 1'b0;
         w_ctrl.if_id_write   = 1'b0;
         w_ctrl.id_ex_bubble  = 1'b1;
      end else if (r_state == RUN && branch_taken_i) begin
         w_ctrl.if_id_flush   = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         RUN: begin
            if (w_mem_hold)
               w_state_nxt = MEM_WAIT;
            else if (div_start_i && !div_done_i)
               w_state_nxt = DIV_WAIT;
         end
         MEM_WAIT: if (dmem_ack_i) w_state_nxt = RUN;
         DIV_WAIT: if (div_done_i) w_state_nxt = RUN;
         default:  w_state_nxt = RUN;
      endcase
   end

   assign w_tmo_inc = (&r_tmo) ? r_tmo : r_tmo + TMO_W'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= RUN;
         r_tmo       <= '0;
         r_err       <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == RUN && w_state_nxt == MEM_WAIT) begin
            r_tmo <= '0;
         end else if (r_state == MEM_WAIT) begin
            r_tmo <= w_tmo_inc;
            if (w_tmo_inc >= TMO_LIM)
               r_err <= 1'b1;
         end
         if (!w_ctrl.pc_write && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign pc_write_o      = w_ctrl.pc_write;
   assign if_id_write_o   = w_ctrl.if_id_write;
   assign if_id_flush_o   = w_ctrl.if_id_flush;
   assign id_ex_write_o   = w_ctrl.id_ex_write;
   assign id_ex_bubble_o  = w_ctrl.id_ex_bubble;
   assign ex_mem_write_o  = w_ctrl.ex_mem_write;
   assign ex_mem_bubble_o = w_ctrl.ex_mem_bubble;
   assign mem_wb_bubble_o = w_ctrl.mem_wb_bubble;
   assign state_o         = r_state;
   assign err_o           = r_err;
   assign stall_cnt_o     = r_stall_cnt;

endmodule
